// File: rtl/lc3b_types.sv
// Package: lc3b_types
// Shared LC-3b pipeline types used by the MEM-stage memory access unit.
//  - data-path widths
//  - lc3b_opcode          : 4-bit LC-3b opcode encoding
//  - lc3b_control_word    : decoded control fields consumed in the MEM stage
//  - mau_state_t          : memory access unit FSM states
//  - byte_lane()          : picks the addressed byte out of a fetched word
package lc3b_types;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    // Only the fields the MEM stage looks at are carried in this slice.
    typedef struct packed {
        lc3b_opcode opcode;
        logic       read;
        logic       write;
        logic       indirect_rw;
    } lc3b_control_word;

    typedef enum logic [1:0] {
        IDLE,
        IND,
        DATA,
        DONE
    } mau_state_t;

    // Little-endian byte select: odd addresses take the high byte.
    function automatic logic [7:0] byte_lane(input logic addr0, input logic [15:0] word);
        return addr0 ? word[15:8] : word[7:0];
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Module: mem_access_unit
// MEM-stage data-memory sequencer for the pipelined LC-3b. A live memory
// instruction is latched on acceptance and turned into one (LDR/LDB/STR/STB)
// or two (LDI/STI: pointer read, then data access) memory handshakes. The
// upstream pipeline is held with stall until the access finishes, and done
// pulses for one cycle as the stage is released.
// Ports:
//  clk, rst_n        clock, asynchronous active-low reset
//  valid, ctrl       live instruction and its decoded control word
//  addr, wdata       effective address and store data
//  dmem_*            data-memory request/response handshake
//  rdata             aligned, zero-extended load result
//  done, stall       completion pulse and pipeline hold
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  lc3b_control_word  ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [1:0]        dmem_wmask,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              stall
);

    localparam int HALF = DATA_W / 2;

    mau_state_t        state;
    mau_state_t        state_next;

    logic              mem_op;
    logic              accept;

    lc3b_opcode        opcode_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic              indirect_q;
    logic [DATA_W-1:0] ptr;

    logic              is_byte;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] word_addr;

    assign mem_op    = valid & (ctrl.read | ctrl.write);
    assign accept    = (state == IDLE) & mem_op;
    assign is_byte   = (opcode_q == op_ldb) | (opcode_q == op_stb);
    assign target    = indirect_q ? ADDR_W'(ptr) : addr_q;
    assign word_addr = {target[ADDR_W-1:1], 1'b0};

    // State register. Reset drops the FSM to IDLE, which removes the memory
    // strobes immediately because they are decoded from the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The request is captured once at acceptance so the access finishes
    // intact even if valid or ctrl change while the stage is stalled. Write
    // beats read when both flags are set, so only the write flag is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q   <= op_br;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            indirect_q <= 1'b0;
        end else if (accept) begin
            opcode_q   <= ctrl.opcode;
            addr_q     <= addr;
            wdata_q    <= wdata;
            write_q    <= ctrl.write;
            indirect_q <= ctrl.indirect_rw;
        end
    end

    // Pointer for LDI/STI comes back from the first read; the load result is
    // captured on the data response, byte loads aligned and zero-extended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            rdata <= '0;
        end else begin
            if ((state == IND) && dmem_resp) begin
                ptr <= dmem_rdata;
            end
            if ((state == DATA) && dmem_resp && !write_q) begin
                if (is_byte) begin
                    rdata <= {{(DATA_W-8){1'b0}}, byte_lane(target[0], dmem_rdata)};
                end else begin
                    rdata <= dmem_rdata;
                end
            end
        end
    end

    // Next-state and output decode. Memory-side outputs depend only on the
    // state and the latched request, never on live pipeline inputs, so the
    // address and strobes hold steady from request until response. Only the
    // IDLE stall looks at the live inputs, to freeze the pipe in the cycle
    // an access is accepted. DONE releases the stall for one cycle so the
    // stage can advance before a new request can be taken.
    always_comb begin
        state_next = state;
        dmem_addr  = '0;
        dmem_read  = 1'b0;
        dmem_write = 1'b0;
        dmem_wmask = 2'b00;
        dmem_wdata = '0;
        done       = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = mem_op;
                if (mem_op) begin
                    state_next = ctrl.indirect_rw ? IND : DATA;
                end
            end
            IND: begin
                stall     = 1'b1;
                dmem_read = 1'b1;
                dmem_addr = {addr_q[ADDR_W-1:1], 1'b0};
                if (dmem_resp) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                stall     = 1'b1;
                dmem_addr = word_addr;
                if (write_q) begin
                    dmem_write = 1'b1;
                    if (is_byte) begin
                        dmem_wmask = target[0] ? 2'b10 : 2'b01;
                        dmem_wdata = {2{wdata_q[HALF-1:0]}};
                    end else begin
                        dmem_wmask = 2'b11;
                        dmem_wdata = wdata_q;
                    end
                end else begin
                    dmem_read = 1'b1;
                end
                if (dmem_resp) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench: tb_mem_access_unit
// Drives mem_access_unit with directed and random LC-3b memory instructions.
// A reference model computes, per instruction, the expected memory-bus
// transactions and the expected load result; these go into queues that are
// drained by an independent memory responder and a done monitor.
module tb_mem_access_unit;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid = 1'b0;
    lc3b_control_word ctrl = '0;
    logic [15:0]      addr = '0;
    logic [15:0]      wdata = '0;
    logic [15:0]      dmem_addr;
    logic             dmem_read;
    logic             dmem_write;
    logic [1:0]       dmem_wmask;
    logic [15:0]      dmem_wdata;
    logic [15:0]      dmem_rdata;
    logic             dmem_resp;
    logic [15:0]      rdata;
    logic             done;
    logic             stall;

    typedef struct {
        logic        isWrite;
        logic [15:0] addr;
        logic [1:0]  mask;
        logic [15:0] data;
    } busItem_t;

    typedef struct {
        logic        isLoad;
        logic [15:0] data;
    } doneItem_t;

    busItem_t    busQ[$];
    doneItem_t   doneQ[$];
    logic [15:0] refMem[int];
    logic [15:0] busMem[int];

    int vectors = 0;
    int miscompares = 0;
    int forceWait = -1;
    int sumWaits = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid      (valid),
        .ctrl       (ctrl),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_addr  (dmem_addr),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .rdata      (rdata),
        .done       (done),
        .stall      (stall)
    );

    // Contents of memory words never written by the bench.
    function automatic logic [15:0] imageWord(input int idx);
        return 16'(idx * 40503) ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] refRead(input logic [15:0] a);
        int idx = int'(a[15:1]);
        return refMem.exists(idx) ? refMem[idx] : imageWord(idx);
    endfunction

    function automatic logic [15:0] busRead(input logic [15:0] a);
        int idx = int'(a[15:1]);
        return busMem.exists(idx) ? busMem[idx] : imageWord(idx);
    endfunction

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, actual, required, $time);
        end
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] word);
        refMem[int'(a[15:1])] = word;
        busMem[int'(a[15:1])] = word;
    endtask

    // Memory responder: checks every new request against the expected bus
    // queue, checks the address holds while waiting, then answers after a
    // chosen number of wait cycles.
    initial begin : responder
        int       waitLeft;
        logic [15:0] reqAddr;
        logic [15:0] word;
        busItem_t exp;
        waitLeft   = -1;
        reqAddr    = '0;
        dmem_resp  = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            dmem_resp = 1'b0;
            if (!rst_n || !(dmem_read || dmem_write)) begin
                waitLeft = -1;
            end else begin
                if (waitLeft < 0) begin
                    checkOutput("single strobe", 32'(dmem_read & dmem_write), 32'(0));
                    reqAddr  = dmem_addr;
                    waitLeft = (forceWait >= 0) ? forceWait : int'($urandom_range(0, 2));
                    sumWaits += waitLeft;
                    checkOutput("expected bus access", 32'(busQ.size() != 0), 32'(1));
                    if (busQ.size() != 0) begin
                        exp = busQ.pop_front();
                        checkOutput("bus direction", 32'(dmem_write), 32'(exp.isWrite));
                        checkOutput("bus addr", 32'(dmem_addr), 32'(exp.addr));
                        if (exp.isWrite) begin
                            checkOutput("bus wmask", 32'(dmem_wmask), 32'(exp.mask));
                            checkOutput("bus wdata", 32'(dmem_wdata), 32'(exp.data));
                        end
                    end
                end else begin
                    checkOutput("addr stable", 32'(dmem_addr), 32'(reqAddr));
                end
                if (waitLeft == 0) begin
                    if (dmem_write) begin
                        word = busRead(dmem_addr);
                        if (dmem_wmask[1]) word[15:8] = dmem_wdata[15:8];
                        if (dmem_wmask[0]) word[7:0] = dmem_wdata[7:0];
                        busMem[int'(dmem_addr[15:1])] = word;
                    end else begin
                        dmem_rdata = busRead(dmem_addr);
                    end
                    dmem_resp = 1'b1;
                    waitLeft  = -1;
                end else begin
                    waitLeft--;
                end
            end
        end
    end

    // Done monitor: every done pulse must match a queued instruction, and
    // loads must present the model's result.
    initial begin : doneMonitor
        doneItem_t exp;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                checkOutput("expected done", 32'(doneQ.size() != 0), 32'(1));
                if (doneQ.size() != 0) begin
                    exp = doneQ.pop_front();
                    if (exp.isLoad) begin
                        checkOutput("load rdata", 32'(rdata), 32'(exp.data));
                    end
                end
            end
        end
    end

    // Issue one instruction: the model queues the expected bus traffic and
    // result, then the instruction is presented for one accepted cycle and
    // replaced by junk with valid low while the access runs.
    task automatic applyStimulus(input lc3b_opcode op, input logic rd, input logic wr,
                                 input logic ind, input logic [15:0] a,
                                 input logic [15:0] w, input int waits);
        busItem_t    b;
        doneItem_t   d;
        logic [15:0] target;
        logic [15:0] word;
        logic        isByte;
        int          cycles;
        bit          seen;

        if (ind) begin
            b.isWrite = 1'b0;
            b.addr    = {a[15:1], 1'b0};
            b.mask    = 2'b00;
            b.data    = '0;
            busQ.push_back(b);
            target = refRead(a);
        end else begin
            target = a;
        end
        isByte = (op == op_ldb) || (op == op_stb);
        word   = refRead(target);
        b.addr = {target[15:1], 1'b0};
        if (wr) begin
            b.isWrite = 1'b1;
            if (isByte) begin
                b.data = {w[7:0], w[7:0]};
                b.mask = target[0] ? 2'b10 : 2'b01;
                if (target[0]) word[15:8] = w[7:0];
                else           word[7:0]  = w[7:0];
            end else begin
                b.data = w;
                b.mask = 2'b11;
                word   = w;
            end
            refMem[int'(target[15:1])] = word;
            d.isLoad = 1'b0;
            d.data   = '0;
        end else begin
            b.isWrite = 1'b0;
            b.mask    = 2'b00;
            b.data    = '0;
            d.isLoad  = 1'b1;
            d.data    = isByte ? {8'h00, (target[0] ? word[15:8] : word[7:0])} : word;
        end
        busQ.push_back(b);
        doneQ.push_back(d);

        forceWait = waits;
        sumWaits  = 0;
        @(negedge clk);
        valid             = 1'b1;
        ctrl.opcode       = op;
        ctrl.read         = rd;
        ctrl.write        = wr;
        ctrl.indirect_rw  = ind;
        addr              = a;
        wdata             = w;
        #1 checkOutput("stall at accept", 32'(stall), 32'(1));
        @(posedge clk);
        #1;
        valid = 1'b0;
        ctrl  = 7'($urandom);
        addr  = 16'($urandom);
        wdata = 16'($urandom);

        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 60) begin
            @(negedge clk);
            #1;
            cycles++;
            if (done) begin
                seen = 1'b1;
                checkOutput("stall at done", 32'(stall), 32'(0));
                checkOutput("latency", 32'(cycles), 32'((ind ? 3 : 2) + sumWaits));
            end else begin
                checkOutput("stall while busy", 32'(stall), 32'(1));
            end
        end
        checkOutput("done seen", 32'(seen), 32'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        busItem_t   b;
        lc3b_opcode op;
        logic       rd, wr, ind;
        int         pick;

        #1;
        checkOutput("reset dmem_read", 32'(dmem_read), 32'(0));
        checkOutput("reset dmem_write", 32'(dmem_write), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset stall", 32'(stall), 32'(0));
        checkOutput("reset dmem_addr", 32'(dmem_addr), 32'(0));
        checkOutput("reset dmem_wmask", 32'(dmem_wmask), 32'(0));
        checkOutput("reset rdata", 32'(rdata), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released");

        // Directed cases from the block's worked examples.
        preload(16'h3004, 16'hBEEF);
        applyStimulus(op_ldr, 1'b1, 1'b0, 1'b0, 16'h3004, 16'h0000, 0);
        preload(16'h3004, 16'hA55A);
        applyStimulus(op_ldb, 1'b1, 1'b0, 1'b0, 16'h3005, 16'h0000, 0);
        applyStimulus(op_stb, 1'b0, 1'b1, 1'b0, 16'h4000, 16'h12CD, 0);
        preload(16'h2000, 16'h5002);
        preload(16'h5002, 16'h0777);
        applyStimulus(op_ldi, 1'b1, 1'b0, 1'b1, 16'h2000, 16'h0000, 2);
        preload(16'h2100, 16'h6000);
        applyStimulus(op_sti, 1'b0, 1'b1, 1'b1, 16'h2100, 16'h1234, 0);
        applyStimulus(op_ldr, 1'b1, 1'b0, 1'b0, 16'h6000, 16'h0000, 1);
        // Read and write both set: behaves as a store.
        applyStimulus(op_ldr, 1'b1, 1'b1, 1'b0, 16'h3100, 16'h9876, 0);
        applyStimulus(op_ldr, 1'b1, 1'b0, 1'b0, 16'h3100, 16'h0000, 0);

        // Non-memory instruction: no stall, no strobe, no done.
        @(negedge clk);
        valid       = 1'b1;
        ctrl        = '0;
        ctrl.opcode = op_add;
        #1 checkOutput("stall on non-mem op", 32'(stall), 32'(0));
        @(negedge clk);
        #1 checkOutput("strobe on non-mem op", 32'(dmem_read | dmem_write), 32'(0));
        valid = 1'b0;

        // Reset in the middle of a store's data phase.
        b.isWrite = 1'b1;
        b.addr    = 16'h7000;
        b.mask    = 2'b11;
        b.data    = 16'hA5A5;
        busQ.push_back(b);
        forceWait = 6;
        @(negedge clk);
        valid            = 1'b1;
        ctrl.opcode      = op_str;
        ctrl.read        = 1'b0;
        ctrl.write       = 1'b1;
        ctrl.indirect_rw = 1'b0;
        addr             = 16'h7000;
        wdata            = 16'hA5A5;
        @(posedge clk);
        #1 valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (dmem_write) break;
        end
        checkOutput("write strobe before reset", 32'(dmem_write), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("write drops on reset", 32'(dmem_write), 32'(0));
        checkOutput("read low on reset", 32'(dmem_read), 32'(0));
        checkOutput("stall low on reset", 32'(stall), 32'(0));
        checkOutput("done low on reset", 32'(done), 32'(0));
        checkOutput("rdata cleared on reset", 32'(rdata), 32'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        // The aborted store never reached memory, so the old word reads back.
        applyStimulus(op_ldr, 1'b1, 1'b0, 1'b0, 16'h7000, 16'h0000, 0);

        // Random traffic in a small window so loads hit earlier stores.
        for (int n = 0; n < 150; n++) begin
            pick = int'($urandom_range(0, 5));
            case (pick)
                0: begin op = op_ldr; rd = 1'b1; wr = 1'b0; ind = 1'b0; end
                1: begin op = op_ldb; rd = 1'b1; wr = 1'b0; ind = 1'b0; end
                2: begin op = op_str; rd = 1'b0; wr = 1'b1; ind = 1'b0; end
                3: begin op = op_stb; rd = 1'b0; wr = 1'b1; ind = 1'b0; end
                4: begin op = op_ldi; rd = 1'b1; wr = 1'b0; ind = 1'b1; end
                default: begin op = op_sti; rd = 1'b0; wr = 1'b1; ind = 1'b1; end
            endcase
            if (rd && !ind && $urandom_range(0, 7) == 0) wr = 1'b1;
            applyStimulus(op, rd, wr, ind, 16'h8000 | 16'($urandom_range(0, 255)),
                          16'($urandom), -1);
        end

        repeat (3) @(negedge clk);
        checkOutput("bus queue drained", 32'(busQ.size()), 32'(0));
        checkOutput("done queue drained", 32'(doneQ.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
